// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory req/ack port between mem_stage and memory
interface mem_stage_if;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_be;
   logic        dm_ack;
   logic [31:0] dm_rdata;

   modport master (
      output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
      input  dm_ack, dm_rdata
   );

   modport slave (
      input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
      output dm_ack, dm_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with stall and access timeout
module mem_stage #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [4:0]  in_rd,
   input  logic        in_read,
   input  logic        in_write,
   input  logic [1:0]  in_size,
   input  logic        in_unsigned,
   output logic        stall,
   mem_stage_if.master dm,
   output logic        wb_valid,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_rd,
   output logic        misalign,
   output logic        bus_err
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t      state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [4:0]  lat_rd;
   logic [1:0]  lat_off;
   logic [1:0]  lat_size;
   logic        lat_uns;

   logic        is_mem, aligned, start, timeout;
   logic [3:0]  be_nxt;
   logic [31:0] wdata_nxt;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_val;

   assign is_mem  = in_read | in_write;
   assign aligned = (in_size == 2'b00) ||
                    (in_size == 2'b01 && !in_addr[0]) ||
                    (in_size[1] && in_addr[1:0] == 2'b00);
   assign start   = (state == IDLE) && in_valid && is_mem && aligned;
   assign timeout = (state == ACCESS) && !dm.dm_ack && (cnt == CNT_W'(TIMEOUT - 1));

   // Gated by reset so the pipeline is never held while the stage is in reset
   assign stall = reset && (start || (state == ACCESS && !dm.dm_ack && !timeout));

   always_comb begin
      be_nxt    = 4'b1111;
      wdata_nxt = in_wdata;
      case (in_size)
         2'b00: begin
            be_nxt    = 4'b0001 << in_addr[1:0];
            wdata_nxt = {4{in_wdata[7:0]}};
         end
         2'b01: begin
            be_nxt    = in_addr[1] ? 4'b1100 : 4'b0011;
            wdata_nxt = {2{in_wdata[15:0]}};
         end
         default: begin
            be_nxt    = 4'b1111;
            wdata_nxt = in_wdata;
         end
      endcase
   end

   always_comb begin
      ld_byte = dm.dm_rdata[7:0];
      case (lat_off)
         2'b00:   ld_byte = dm.dm_rdata[7:0];
         2'b01:   ld_byte = dm.dm_rdata[15:8];
         2'b10:   ld_byte = dm.dm_rdata[23:16];
         default: ld_byte = dm.dm_rdata[31:24];
      endcase
      ld_half = lat_off[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];
      ld_val  = dm.dm_rdata;
      case (lat_size)
         2'b00:   ld_val = {{24{ld_byte[7] & ~lat_uns}}, ld_byte};
         2'b01:   ld_val = {{16{ld_half[15] & ~lat_uns}}, ld_half};
         default: ld_val = dm.dm_rdata;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ACCESS;
         ACCESS:  if (dm.dm_ack || timeout) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt         <= '0;
         dm.dm_req   <= 1'b0;
         dm.dm_we    <= 1'b0;
         dm.dm_addr  <= '0;
         dm.dm_wdata <= '0;
         dm.dm_be    <= '0;
         lat_rd      <= '0;
         lat_off     <= '0;
         lat_size    <= '0;
         lat_uns     <= 1'b0;
         wb_valid    <= 1'b0;
         wb_data     <= '0;
         wb_rd       <= '0;
         misalign    <= 1'b0;
         bus_err     <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         misalign <= 1'b0;
         bus_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid && !is_mem) begin
                  wb_data  <= in_addr;
                  wb_rd    <= in_rd;
                  wb_valid <= 1'b1;
               end else if (in_valid && !aligned) begin
                  misalign <= 1'b1;
               end else if (start) begin
                  dm.dm_req   <= 1'b1;
                  dm.dm_we    <= in_write;
                  dm.dm_addr  <= {in_addr[31:2], 2'b00};
                  dm.dm_wdata <= wdata_nxt;
                  dm.dm_be    <= be_nxt;
                  lat_rd      <= in_rd;
                  lat_off     <= in_addr[1:0];
                  lat_size    <= in_size;
                  lat_uns     <= in_unsigned;
                  cnt         <= '0;
               end
            end
            ACCESS: begin
               if (dm.dm_ack) begin
                  dm.dm_req <= 1'b0;
                  if (!dm.dm_we) begin
                     wb_data  <= ld_val;
                     wb_rd    <= lat_rd;
                     wb_valid <= 1'b1;
                  end
               end else if (timeout) begin
                  dm.dm_req <= 1'b0;
                  bus_err   <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
`timescale 1ns/1ps
module tb_mem_stage;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;
   logic [4:0]  in_rd;
   logic        in_read;
   logic        in_write;
   logic [1:0]  in_size;
   logic        in_unsigned;
   logic        stall;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        misalign;
   logic        bus_err;

   int n_checks = 0;
   int n_fail   = 0;

   mem_stage_if dm ();

   mem_stage #(.TIMEOUT(4), .CNT_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_addr     (in_addr),
      .in_wdata    (in_wdata),
      .in_rd       (in_rd),
      .in_read     (in_read),
      .in_write    (in_write),
      .in_size     (in_size),
      .in_unsigned (in_unsigned),
      .stall       (stall),
      .dm          (dm.master),
      .wb_valid    (wb_valid),
      .wb_data     (wb_data),
      .wb_rd       (wb_rd),
      .misalign    (misalign),
      .bus_err     (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input logic rd_en, input logic wr_en, input logic [1:0] size, input logic uns);
      in_valid    = 1'b1;
      in_addr     = addr;
      in_wdata    = wdata;
      in_rd       = rd;
      in_read     = rd_en;
      in_write    = wr_en;
      in_size     = size;
      in_unsigned = uns;
   endtask

   // One aligned access: issue, hold without ack for wait_cyc-1 cycles, then ack
   task automatic mem_op(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic wr_en, input logic [1:0] size,
                         input logic uns, input logic [31:0] rdata, input int wait_cyc,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_wb);
      drive(addr, wdata, rd, !wr_en, wr_en, size, uns);
      #1 check({tag, "_stall_issue"}, 32'(stall), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, "_req"},  32'(dm.dm_req), 32'd1);
      check({tag, "_we"},   32'(dm.dm_we),  32'(wr_en));
      check({tag, "_addr"}, dm.dm_addr,     exp_addr);
      check({tag, "_be"},   32'(dm.dm_be),  32'(exp_be));
      if (wr_en) check({tag, "_wdata"}, dm.dm_wdata, exp_wdata);
      for (int i = 1; i < wait_cyc; i++) begin
         check({tag, "_stall_wait"}, 32'(stall), 32'd1);
         @(negedge clk);
      end
      dm.dm_ack   = 1'b1;
      dm.dm_rdata = rdata;
      #1 check({tag, "_stall_ack"}, 32'(stall), 32'd0);
      @(negedge clk);
      dm.dm_ack = 1'b0;
      check({tag, "_req_drop"}, 32'(dm.dm_req), 32'd0);
      check({tag, "_wb_valid"}, 32'(wb_valid),  32'(!wr_en));
      if (!wr_en) begin
         check({tag, "_wb_data"}, wb_data,     exp_wb);
         check({tag, "_wb_rd"},   32'(wb_rd), 32'(rd));
      end
      @(negedge clk);
      check({tag, "_wb_pulse"}, 32'(wb_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b0;
      dm.dm_ack   = 1'b0;
      dm.dm_rdata = '0;
      drive(32'h0000_0100, 32'h0, 5'd1, 1'b0, 1'b1, 2'b10, 1'b0);
      repeat (3) @(negedge clk);
      check("rst_req",      32'(dm.dm_req), 32'd0);
      check("rst_stall",    32'(stall),     32'd0);
      check("rst_wb_valid", 32'(wb_valid),  32'd0);
      check("rst_misalign", 32'(misalign),  32'd0);
      check("rst_bus_err",  32'(bus_err),   32'd0);
      in_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clk);

      drive(32'h0000_0042, 32'h0, 5'd3, 1'b0, 1'b0, 2'b10, 1'b0);
      #1 check("pass_stall", 32'(stall), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      check("pass_wb_valid", 32'(wb_valid), 32'd1);
      check("pass_wb_data",  wb_data,       32'h0000_0042);
      check("pass_wb_rd",    32'(wb_rd),    32'd3);
      check("pass_req",      32'(dm.dm_req), 32'd0);
      @(negedge clk);
      check("pass_pulse", 32'(wb_valid), 32'd0);

      mem_op("lw",  32'h0000_0100, 32'h0, 5'd5, 1'b0, 2'b10, 1'b0, 32'hA5A5_A5A5, 3,
             32'h0000_0100, 4'b1111, 32'h0, 32'hA5A5_A5A5);
      mem_op("lb",  32'h0000_0103, 32'h0, 5'd6, 1'b0, 2'b00, 1'b0, 32'h80FF_FF7F, 1,
             32'h0000_0100, 4'b1000, 32'h0, 32'hFFFF_FF80);
      mem_op("lbu", 32'h0000_0103, 32'h0, 5'd7, 1'b0, 2'b00, 1'b1, 32'h80FF_FF7F, 1,
             32'h0000_0100, 4'b1000, 32'h0, 32'h0000_0080);
      mem_op("lh",  32'h0000_0102, 32'h0, 5'd8, 1'b0, 2'b01, 1'b0, 32'h8001_0000, 2,
             32'h0000_0100, 4'b1100, 32'h0, 32'hFFFF_8001);
      mem_op("sb",  32'h0000_0201, 32'h5A5A_5A5A, 5'd9, 1'b1, 2'b00, 1'b0, 32'h0, 1,
             32'h0000_0200, 4'b0010, 32'h5A5A_5A5A, 32'h0);
      mem_op("sh",  32'h0000_0202, 32'h1234_5678, 5'd10, 1'b1, 2'b01, 1'b0, 32'h0, 2,
             32'h0000_0200, 4'b1100, 32'h5678_5678, 32'h0);

      drive(32'h0000_0102, 32'h0, 5'd11, 1'b1, 1'b0, 2'b10, 1'b0);
      #1 check("mis_stall", 32'(stall), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      check("mis_pulse",    32'(misalign),  32'd1);
      check("mis_req",      32'(dm.dm_req), 32'd0);
      check("mis_wb_valid", 32'(wb_valid),  32'd0);
      @(negedge clk);
      check("mis_pulse_end", 32'(misalign), 32'd0);

      drive(32'h0000_0300, 32'h0, 5'd12, 1'b1, 1'b0, 2'b10, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("to_stall_wait", 32'(stall),     32'd1);
         check("to_req_wait",   32'(dm.dm_req), 32'd1);
         @(negedge clk);
      end
      check("to_stall_last", 32'(stall),     32'd0);
      check("to_req_last",   32'(dm.dm_req), 32'd1);
      @(negedge clk);
      check("to_bus_err",  32'(bus_err),   32'd1);
      check("to_req_drop", 32'(dm.dm_req), 32'd0);
      check("to_wb_valid", 32'(wb_valid),  32'd0);
      check("to_stall",    32'(stall),     32'd0);
      @(negedge clk);
      check("to_pulse_end", 32'(bus_err), 32'd0);

      drive(32'h0000_0400, 32'h0, 5'd13, 1'b1, 1'b0, 2'b10, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      check("rma_req", 32'(dm.dm_req), 32'd1);
      reset = 1'b0;
      #1 check("rma_req_drop", 32'(dm.dm_req), 32'd0);
      check("rma_stall", 32'(stall), 32'd0);
      @(negedge clk);
      reset       = 1'b1;
      dm.dm_ack   = 1'b1;
      dm.dm_rdata = 32'hDEAD_BEEF;
      #1 check("late_ack_stall", 32'(stall), 32'd0);
      @(negedge clk);
      dm.dm_ack = 1'b0;
      check("late_ack_wb_valid", 32'(wb_valid),  32'd0);
      check("late_ack_req",      32'(dm.dm_req), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
